exec_unit: RTL and testbench

//  Execute stage between decode and the 8x8 register file. Drives the regfile read addresses,

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/shift_add_mul.sv | 47 ++++
 rtl/exec_unit.sv | 133 +++++++++++++
 tb/tb_exec_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute stage and its multiplier.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef logic [1:0] exec_state_t;
    localparam exec_state_t ST_IDLE = 2'd0;
    localparam exec_state_t ST_MUL  = 2'd1;
    localparam exec_state_t ST_WB   = 2'd2;

endpackage

// File: rtl/shift_add_mul.sv
// Shift-add multiplier, one multiplier bit per cycle; product is valid while done is high.
module shift_add_mul
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [2:0]          count;

    // product already includes the current step, so the final sum is ready on the last busy cycle
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 3'd1;
            if (count == 3'd7)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: forwards its own writeback, runs the ALU in one cycle or MUL over nine.
module exec_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] srcA_i,
    input  logic [ADDR_W-1:0] srcB_i,
    input  logic [ADDR_W-1:0] dest_i,
    output logic [ADDR_W-1:0] sourceReg1_o,
    output logic [ADDR_W-1:0] sourceReg2_o,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic              writeFlag_o,
    output logic [ADDR_W-1:0] destReg_o,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o,
    output logic              carry_o
);

    exec_state_t           state;
    alu_op_t               op;
    logic                  accept;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_carry;
    logic [DATA_W:0]       shl_full;
    logic [DATA_W:0]       shr_full;
    logic [2:0]            shift;
    logic [ADDR_W-1:0]     mul_dest;
    logic                  mul_start;
    logic                  mul_busy;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;

    assign sourceReg1_o = srcA_i;
    assign sourceReg2_o = srcB_i;
    assign op           = alu_op_t'(op_i);
    assign ready_o      = !mul_busy;
    assign accept       = valid_i && ready_o;
    assign mul_start    = accept && (op == OP_MUL);

    // The regfile only sees our write one edge later, so bypass it while the pulse is live
    assign op_a = (writeFlag_o && destReg_o == srcA_i) ? data_o : data1_i;
    assign op_b = (writeFlag_o && destReg_o == srcB_i) ? data_o : data2_i;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        shl_full  = '0;
        shr_full  = '0;
        shift     = op_b[2:0];
        case (op)
            OP_ADD: {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            // The extra bit on each side catches the last bit shifted out
            OP_SHL: begin
                shl_full  = {1'b0, op_a} << shift;
                alu_res   = shl_full[DATA_W-1:0];
                alu_carry = shl_full[DATA_W];
            end
            OP_SHR: begin
                shr_full  = {op_a, 1'b0} >> shift;
                alu_res   = shr_full[DATA_W:1];
                alu_carry = shr_full[0];
            end
            default: ;
        endcase
    end

    shift_add_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            writeFlag_o <= 1'b0;
            destReg_o   <= '0;
            data_o      <= '0;
            zero_o      <= 1'b0;
            carry_o     <= 1'b0;
            mul_dest    <= '0;
        end else begin
            writeFlag_o <= 1'b0;
            case (state)
                ST_MUL: begin
                    if (mul_done) begin
                        state       <= ST_WB;
                        writeFlag_o <= 1'b1;
                        destReg_o   <= mul_dest;
                        data_o      <= mul_product[DATA_W-1:0];
                        zero_o      <= (mul_product[DATA_W-1:0] == '0);
                        carry_o     <= |mul_product[2*DATA_W-1:DATA_W];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state    <= ST_MUL;
                            mul_dest <= dest_i;
                        end else begin
                            writeFlag_o <= 1'b1;
                            destReg_o   <= dest_i;
                            data_o      <= alu_res;
                            zero_o      <= (alu_res == '0);
                            carry_o     <= alu_carry;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit with an 8x8 regfile and an arithmetic reference model of the ISA.
module tb_exec_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic       ready_o;
    logic [2:0] op_i;
    logic [2:0] srcA_i;
    logic [2:0] srcB_i;
    logic [2:0] dest_i;
    logic [2:0] sourceReg1_o;
    logic [2:0] sourceReg2_o;
    logic [7:0] data1_i;
    logic [7:0] data2_i;
    logic       writeFlag_o;
    logic [2:0] destReg_o;
    logic [7:0] data_o;
    logic       zero_o;
    logic       carry_o;

    logic [7:0] rf [8];
    logic       rf_load;
    logic [7:0] ref_rf [8];
    logic [7:0] last_data;
    logic [2:0] last_dest;
    int         errors = 0;
    int         checks = 0;
    int         pulse_count = 0;
    int         pc0;

    exec_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .srcA_i       (srcA_i),
        .srcB_i       (srcB_i),
        .dest_i       (dest_i),
        .sourceReg1_o (sourceReg1_o),
        .sourceReg2_o (sourceReg2_o),
        .data1_i      (data1_i),
        .data2_i      (data2_i),
        .writeFlag_o  (writeFlag_o),
        .destReg_o    (destReg_o),
        .data_o       (data_o),
        .zero_o       (zero_o),
        .carry_o      (carry_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_load) begin
            rf[0] <= 8'd8; rf[1] <= 8'd7; rf[2] <= 8'd6; rf[3] <= 8'd0;
            rf[4] <= 8'd4; rf[5] <= 8'd0; rf[6] <= 8'd0; rf[7] <= 8'd0;
        end else if (writeFlag_o) begin
            rf[destReg_o] <= data_o;
        end
    end

    assign data1_i = rf[sourceReg1_o];
    assign data2_i = rf[sourceReg2_o];

    always @(posedge clk) if (writeFlag_o) pulse_count <= pulse_count + 1;

    function automatic void refCompute(input logic [2:0] op, input int a, input int b,
                                       output int res, output int cy);
        int s;
        int full;
        s = b % 8;
        res = 0;
        cy = 0;
        case (op)
            OP_ADD: begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
            OP_SUB: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin full = a * (1 << s); res = full % 256; cy = (full / 256) % 2; end
            OP_SHR: begin res = a / (1 << s); cy = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2; end
            default: begin full = a * b; res = full % 256; cy = (full > 255) ? 1 : 0; end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] a,
                                 input logic [2:0] b, input logic [2:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = op;
        srcA_i  = a;
        srcB_i  = b;
        dest_i  = d;
    endtask

    task automatic checkAlu();
        int a, b, res, cy;
        logic [2:0] d;
        a = ref_rf[srcA_i];
        b = ref_rf[srcB_i];
        d = dest_i;
        refCompute(op_i, a, b, res, cy);
        @(posedge clk); #1;
        checkOutput("alu_wflag", 16'(writeFlag_o), 16'd1);
        checkOutput("alu_dest", 16'(destReg_o), 16'(d));
        checkOutput("alu_data", 16'(data_o), 16'(res));
        checkOutput("alu_zero", 16'(zero_o), (res == 0) ? 16'd1 : 16'd0);
        checkOutput("alu_carry", 16'(carry_o), 16'(cy));
        checkOutput("alu_ready", 16'(ready_o), 16'd1);
        ref_rf[d] = res[7:0];
        last_data = res[7:0];
        last_dest = d;
    endtask

    task automatic checkMul(input bit hold, input logic [2:0] hop, input logic [2:0] ha,
                            input logic [2:0] hb, input logic [2:0] hd);
        int a, b, res, cy;
        logic [2:0] d;
        a = ref_rf[srcA_i];
        b = ref_rf[srcB_i];
        d = dest_i;
        refCompute(OP_MUL, a, b, res, cy);
        @(posedge clk); #1;
        checkOutput("mul_ready_low", 16'(ready_o), 16'd0);
        checkOutput("mul_no_early_wflag", 16'(writeFlag_o), 16'd0);
        @(negedge clk);
        if (hold) begin
            op_i = hop; srcA_i = ha; srcB_i = hb; dest_i = hd; valid_i = 1'b1;
        end else begin
            valid_i = 1'b0;
        end
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("mul_busy_ready", 16'(ready_o), 16'd0);
            checkOutput("mul_busy_wflag", 16'(writeFlag_o), 16'd0);
        end
        @(posedge clk); #1;
        checkOutput("mul_wflag", 16'(writeFlag_o), 16'd1);
        checkOutput("mul_dest", 16'(destReg_o), 16'(d));
        checkOutput("mul_data", 16'(data_o), 16'(res));
        checkOutput("mul_zero", 16'(zero_o), (res == 0) ? 16'd1 : 16'd0);
        checkOutput("mul_carry", 16'(carry_o), 16'(cy));
        checkOutput("mul_ready_wb", 16'(ready_o), 16'd1);
        ref_rf[d] = res[7:0];
        last_data = res[7:0];
        last_dest = d;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_wflag", 16'(writeFlag_o), 16'd0);
        checkOutput("idle_data_hold", 16'(data_o), 16'(last_data));
        checkOutput("idle_dest_hold", 16'(destReg_o), 16'(last_dest));
    endtask

    initial begin
        logic [2:0] rop;
        rst_n = 1'b0; valid_i = 1'b0; rf_load = 1'b1;
        op_i = '0; srcA_i = '0; srcB_i = '0; dest_i = '0;
        ref_rf[0] = 8'd8; ref_rf[1] = 8'd7; ref_rf[2] = 8'd6; ref_rf[3] = 8'd0;
        ref_rf[4] = 8'd4; ref_rf[5] = 8'd0; ref_rf[6] = 8'd0; ref_rf[7] = 8'd0;
        last_data = '0; last_dest = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 16'(ready_o), 16'd1);
        checkOutput("rst_wflag", 16'(writeFlag_o), 16'd0);
        checkOutput("rst_dest", 16'(destReg_o), 16'd0);
        checkOutput("rst_data", 16'(data_o), 16'd0);
        checkOutput("rst_zero", 16'(zero_o), 16'd0);
        checkOutput("rst_carry", 16'(carry_o), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; rf_load = 1'b0;

        applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd3);
        checkAlu();
        checkOutput("add_r0_r1_0f", 16'(data_o), 16'h0F);
        idleCycle();

        // dependent pair: SUB must see the fresh r3=14, not the stale 15
        applyStimulus(OP_ADD, 3'd1, 3'd1, 3'd3);
        checkAlu();
        applyStimulus(OP_SUB, 3'd3, 3'd0, 3'd5);
        checkAlu();
        checkOutput("fwd_sub_06", 16'(data_o), 16'h06);

        applyStimulus(OP_SUB, 3'd4, 3'd0, 3'd7);
        checkAlu();
        checkOutput("sub_borrow_fc", 16'(data_o), 16'hFC);
        checkOutput("sub_borrow_c", 16'(carry_o), 16'd1);
        applyStimulus(OP_XOR, 3'd2, 3'd2, 3'd7);
        checkAlu();
        checkOutput("xor_zero", 16'(zero_o), 16'd1);
        idleCycle();

        applyStimulus(OP_MUL, 3'd0, 3'd1, 3'd3);
        checkMul(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        checkOutput("mul_38", 16'(data_o), 16'h38);
        idleCycle();

        applyStimulus(OP_ADD, 3'd0, 3'd0, 3'd6);
        checkAlu();
        applyStimulus(OP_ADD, 3'd6, 3'd6, 3'd6);
        checkAlu();
        applyStimulus(OP_MUL, 3'd6, 3'd0, 3'd3);
        checkMul(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        checkOutput("mul_ovf_data", 16'(data_o), 16'h00);
        checkOutput("mul_ovf_carry", 16'(carry_o), 16'd1);
        checkOutput("mul_ovf_zero", 16'(zero_o), 16'd1);
        idleCycle();

        // second op held on the inputs throughout the multiply
        pc0 = pulse_count;
        applyStimulus(OP_MUL, 3'd1, 3'd2, 3'd5);
        checkMul(1'b1, OP_ADD, 3'd5, 3'd4, 3'd7);
        checkAlu();
        checkOutput("hold_add_fwd", 16'(data_o), 16'd46);
        idleCycle();
        checkOutput("hold_pulses", 16'(pulse_count - pc0), 16'd2);

        applyStimulus(OP_MUL, 3'd1, 3'd2, 3'd4);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 16'(ready_o), 16'd1);
        checkOutput("abort_wflag", 16'(writeFlag_o), 16'd0);
        checkOutput("abort_data", 16'(data_o), 16'd0);
        checkOutput("abort_dest", 16'(destReg_o), 16'd0);
        checkOutput("abort_zero", 16'(zero_o), 16'd0);
        checkOutput("abort_carry", 16'(carry_o), 16'd0);
        pc0 = pulse_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_data = '0;
        last_dest = '0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_no_pulse", 16'(pulse_count - pc0), 16'd0);
        checkOutput("abort_ready_after", 16'(ready_o), 16'd1);
        checkOutput("abort_r4_kept", 16'(rf[4]), 16'(ref_rf[4]));

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            applyStimulus(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)));
            if (rop == OP_MUL)
                checkMul(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
            else
                checkAlu();
            if ($urandom_range(0, 3) == 0)
                idleCycle();
        end
        idleCycle();
        idleCycle();
        for (int r = 0; r < 8; r++)
            checkOutput($sformatf("rf_r%0d", r), 16'(rf[r]), 16'(ref_rf[r]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
